// File: rtl/layer_sequencer.sv
// layer_sequencer
// Table-driven layer scheduler for the CNN layer engine and data-transfer
// engine. The host fills a small descriptor table and pulses start. The block
// then resets the engines, waits for each rising layer_ready, and presents the
// next descriptor on cfg_bus until the table is exhausted or a terminator
// descriptor (type 0 or 9) is met. It also counts run cycles.
module layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int IDX_W      = 3,
  parameter int DESC_W     = 64,
  parameter int TIMEOUT    = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DESC_W-1:0] cfg_data,
  input  logic [IDX_W:0]    num_layers,
  input  logic              start,
  input  logic              layer_ready,
  output logic              eng_rst,
  output logic [3:0]        layer_type,
  output logic [3:0]        pre_layer_type,
  output logic [IDX_W:0]    layer_num,
  output logic [DESC_W-1:0] cfg_bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [23:0]       cycle_cnt
);

  localparam int                TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]        TYPE_INIT = 4'd0;
  localparam logic [3:0]        TYPE_DONE = 4'd9;
  localparam logic [IDX_W:0]    MAX_NUM   = (IDX_W+1)'(MAX_LAYERS);
  localparam logic [IDX_W:0]    NUM_ZERO  = (IDX_W+1)'(0);
  localparam logic [IDX_W:0]    NUM_ONE   = (IDX_W+1)'(1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [23:0]       CNT_MAX   = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Descriptor table and its registered read port
  logic [DESC_W-1:0] desc_mem_r [MAX_LAYERS];
  logic [DESC_W-1:0] rd_data_r;
  logic              rd_en_s;

  // Registered state
  state_t            state_r,          state_s;
  logic              rst_cnt_r,        rst_cnt_s;
  logic [TMR_W-1:0]  timer_r,          timer_s;
  logic              ready_q_r;
  logic [IDX_W:0]    num_layers_r,     num_layers_s;
  logic [IDX_W:0]    layer_num_r,      layer_num_s;
  logic [3:0]        layer_type_r,     layer_type_s;
  logic [3:0]        pre_layer_type_r, pre_layer_type_s;
  logic [DESC_W-1:0] cfg_bus_r,        cfg_bus_s;
  logic              busy_r,           busy_s;
  logic              done_r,           done_s;
  logic              err_r,            err_s;
  logic              eng_rst_r,        eng_rst_s;
  logic [23:0]       cycle_cnt_r,      cycle_cnt_s;

  // Combinational helpers
  logic              rise_s;
  logic              stop_desc_s;
  logic [IDX_W:0]    num_clamp_s;
  logic [3:0]        rd_type_s;

  assign rise_s      = layer_ready & ~ready_q_r;
  assign rd_type_s   = rd_data_r[3:0];
  assign stop_desc_s = (rd_type_s == TYPE_INIT) || (rd_type_s == TYPE_DONE);
  assign num_clamp_s = (num_layers > MAX_NUM) ? MAX_NUM : num_layers;

  // Host writes into the descriptor table; locked out while a run is active
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_r) begin
      desc_mem_r[cfg_addr] <= cfg_data;
    end
  end

  // Registered table read, issued when a layer edge selects the next descriptor
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      rd_data_r <= desc_mem_r[layer_num_r[IDX_W-1:0]];
    end
  end

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    state_s          = state_r;
    rst_cnt_s        = rst_cnt_r;
    timer_s          = timer_r;
    num_layers_s     = num_layers_r;
    layer_num_s      = layer_num_r;
    layer_type_s     = layer_type_r;
    pre_layer_type_s = pre_layer_type_r;
    cfg_bus_s        = cfg_bus_r;
    busy_s           = busy_r;
    done_s           = done_r;
    err_s            = err_r;
    eng_rst_s        = eng_rst_r;
    cycle_cnt_s      = cycle_cnt_r;
    rd_en_s          = 1'b0;

    // Run-time counter: every busy cycle, saturating
    if (busy_r && (cycle_cnt_r != CNT_MAX)) begin
      cycle_cnt_s = cycle_cnt_r + 24'd1;
    end else begin
      cycle_cnt_s = cycle_cnt_r;
    end

    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_s      = S_RST;
          num_layers_s = num_clamp_s;
          done_s       = 1'b0;
          err_s        = 1'b0;
          cycle_cnt_s  = 24'd0;
          busy_s       = 1'b1;
          layer_num_s  = NUM_ZERO;
          layer_type_s = TYPE_INIT;
          eng_rst_s    = 1'b1;
          rst_cnt_s    = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      // Engines held in reset for two cycles before the init layer runs
      S_RST: begin
        if (rst_cnt_r) begin
          state_s   = S_WAIT;
          eng_rst_s = 1'b0;
          timer_s   = TMR_ZERO;
        end else begin
          rst_cnt_s = 1'b1;
        end
      end

      S_WAIT: begin
        if (rise_s) begin
          if (layer_num_r == num_layers_r) begin
            state_s      = S_DONE;
            layer_type_s = TYPE_DONE;
            busy_s       = 1'b0;
            done_s       = 1'b1;
            eng_rst_s    = 1'b0;
          end else begin
            rd_en_s = 1'b1;
            state_s = S_LOAD;
          end
        end else if (timer_r == TMR_LAST) begin
          state_s   = S_ERROR;
          busy_s    = 1'b0;
          err_s     = 1'b1;
          eng_rst_s = 1'b1;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end

      // Descriptor is now on rd_data_r; a terminator ends the run unissued
      S_LOAD: begin
        if (stop_desc_s) begin
          state_s      = S_DONE;
          layer_type_s = TYPE_DONE;
          busy_s       = 1'b0;
          done_s       = 1'b1;
          eng_rst_s    = 1'b0;
        end else begin
          pre_layer_type_s = layer_type_r;
          layer_type_s     = rd_type_s;
          cfg_bus_s        = rd_data_r;
          layer_num_s      = layer_num_r + NUM_ONE;
          timer_s          = TMR_ZERO;
          state_s          = S_WAIT;
        end
      end

      default: begin
        state_s   = S_IDLE;
        busy_s    = 1'b0;
        eng_rst_s = 1'b1;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= S_IDLE;
      rst_cnt_r        <= 1'b0;
      timer_r          <= TMR_ZERO;
      ready_q_r        <= 1'b0;
      num_layers_r     <= NUM_ZERO;
      layer_num_r      <= NUM_ZERO;
      layer_type_r     <= 4'd0;
      pre_layer_type_r <= 4'd0;
      cfg_bus_r        <= {DESC_W{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_r            <= 1'b0;
      eng_rst_r        <= 1'b1;
      cycle_cnt_r      <= 24'd0;
    end else begin
      state_r          <= state_s;
      rst_cnt_r        <= rst_cnt_s;
      timer_r          <= timer_s;
      ready_q_r        <= layer_ready;
      num_layers_r     <= num_layers_s;
      layer_num_r      <= layer_num_s;
      layer_type_r     <= layer_type_s;
      pre_layer_type_r <= pre_layer_type_s;
      cfg_bus_r        <= cfg_bus_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
      err_r            <= err_s;
      eng_rst_r        <= eng_rst_s;
      cycle_cnt_r      <= cycle_cnt_s;
    end
  end

  assign eng_rst        = eng_rst_r;
  assign layer_type     = layer_type_r;
  assign pre_layer_type = pre_layer_type_r;
  assign layer_num      = layer_num_r;
  assign cfg_bus        = cfg_bus_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign cycle_cnt      = cycle_cnt_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer: directed sequences, a table of run shapes
// and randomized runs checked against a descriptor-list reference model.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic [3:0]  num_layers;
  logic        start;
  logic        layer_ready;
  logic        eng_rst;
  logic [3:0]  layer_type;
  logic [3:0]  pre_layer_type;
  logic [3:0]  layer_num;
  logic [63:0] cfg_bus;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] cycle_cnt;

  layer_sequencer #(
    .MAX_LAYERS(8), .IDX_W(3), .DESC_W(64), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_layers(num_layers), .start(start),
    .layer_ready(layer_ready), .eng_rst(eng_rst), .layer_type(layer_type),
    .pre_layer_type(pre_layer_type), .layer_num(layer_num), .cfg_bus(cfg_bus),
    .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int busy_meas = 0;

  // Reference model: descriptor list plus currently presented layer
  logic [63:0] model_tab [8];
  logic [3:0]  exp_num;
  logic [3:0]  exp_type;
  logic [3:0]  exp_pre;
  logic [63:0] exp_cfg;

  typedef struct {
    int         nl;
    int         stop_idx;   // 8 = no terminator placed
    logic [3:0] stop_type;
    int         exp_num;
    int         exp_edges;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_meas++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_desc(input logic [3:0] t, input logic [7:0] fs,
      input logic [7:0] fd, input logic [7:0] fso, input logic [1:0] pad,
      input logic [7:0] kn, input logic [7:0] ks, input logic pt,
      input logic [3:0] pw, input logic [1:0] act);
    logic [63:0] d;
    d = 64'd0;
    d[3:0]   = t;   d[11:4]  = fs;  d[19:12] = fd;  d[27:20] = fso;
    d[29:28] = pad; d[37:30] = kn;  d[45:38] = ks;  d[46]    = pt;
    d[50:47] = pw;  d[52:51] = act;
    return d;
  endfunction

  function automatic logic [63:0] rand_desc(input logic [3:0] t);
    return mk_desc(t, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                   8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 2'($urandom));
  endfunction

  function automatic logic [3:0] rand_type();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 4'd0;
    if (r == 9) return 4'd9;
    return 4'(1 + (r % 3));
  endfunction

  task automatic write_desc(input int idx, input logic [63:0] d);
    cfg_we = 1'b1; cfg_addr = 3'(idx); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    model_tab[idx] = d;
  endtask

  // Start a run and step it edge by edge against the model.
  task automatic do_run(input int nl, input bit hold_start, input bit disturb,
                        input int stop_after, output int edges, output logic [3:0] fin_num);
    int n; bit fin; bit by_count; logic [3:0] old_type; int h; int g;
    logic [23:0] frozen;
    n = (nl > 8) ? 8 : nl;
    exp_num = 4'd0; exp_type = 4'd0; fin = 1'b0; edges = 0;
    busy_meas = 0;
    if (hold_start) layer_ready = 1'b1;
    start = 1'b1; num_layers = 4'(nl);
    tick();
    start = 1'b0; num_layers = 4'($urandom);
    check("start_busy", busy, 1); check("start_err", err, 0);
    check("start_done", done, 0); check("start_num", layer_num, 0);
    check("start_type", layer_type, 0); check("start_cnt", cycle_cnt, 0);
    check("start_engrst", eng_rst, 1);
    tick(); check("rst_hold", eng_rst, 1);
    tick(); check("rst_release", eng_rst, 0);
    if (hold_start) begin
      repeat (6) tick();
      check("held_no_adv_num", layer_num, 0);
      check("held_no_adv_type", layer_type, 0);
      check("held_no_adv_done", done, 0);
      layer_ready = 1'b0;
      tick();
    end
    g = $urandom_range(0, 3);
    repeat (g) tick();
    while (!fin && edges < 12 && edges < stop_after) begin
      old_type = exp_type;
      by_count = (int'(exp_num) == n);
      if (by_count || (model_tab[exp_num[2:0]][3:0] inside {4'd0, 4'd9})) begin
        fin = 1'b1;
      end else begin
        exp_pre  = exp_type;
        exp_type = model_tab[exp_num[2:0]][3:0];
        exp_cfg  = model_tab[exp_num[2:0]];
        exp_num  = exp_num + 4'd1;
      end
      layer_ready = 1'b1;
      tick();
      edges++;
      check("edge_t1_type", layer_type, by_count ? 4'd9 : old_type);
      tick();
      check("edge_type", layer_type, fin ? 4'd9 : exp_type);
      check("edge_num", layer_num, exp_num);
      check("edge_cfg", cfg_bus, exp_cfg);
      check("edge_done", done, fin);
      check("edge_busy", busy, !fin);
      if (!fin) check("edge_pre", pre_layer_type, exp_pre);
      h = $urandom_range(0, 2);
      repeat (h) tick();
      layer_ready = 1'b0;
      tick();
      if (disturb && !fin && ($urandom_range(0, 1) == 1)) begin
        cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_data = {$urandom, $urandom};
        start = 1'b1; num_layers = 4'($urandom);
        tick();
        cfg_we = 1'b0; start = 1'b0;
      end
      g = $urandom_range(0, 3);
      repeat (g) tick();
    end
    if (!fin && edges >= 12) check("run_bound_done", done, 1);
    if (fin) begin
      check("cnt_vs_busy", cycle_cnt, 24'(busy_meas));
      frozen = cycle_cnt;
      tick(); tick();
      check("cnt_frozen", cycle_cnt, frozen);
      check("done_sticky", done, 1);
      check("done_engrst", eng_rst, 0);
      check("done_err", err, 0);
    end
    fin_num = layer_num;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_engrst"}, eng_rst, 1);
    check({tag, "_type"}, layer_type, 0);
    check({tag, "_pre"}, pre_layer_type, 0);
    check({tag, "_num"}, layer_num, 0);
    check({tag, "_cfg"}, cfg_bus, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnt"}, cycle_cnt, 0);
  endtask

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e; logic [3:0] fn; logic [23:0] frz; int nl;
    logic [63:0] d_conv, d_pool, d_fc;

    vecs[0] = '{0, 8, 4'd9, 0, 1};
    vecs[1] = '{3, 8, 4'd9, 3, 4};
    vecs[2] = '{8, 8, 4'd9, 8, 9};
    vecs[3] = '{15, 8, 4'd9, 8, 9};
    vecs[4] = '{5, 1, 4'd9, 1, 2};
    vecs[5] = '{5, 0, 4'd0, 0, 1};
    vecs[6] = '{4, 4, 4'd9, 4, 5};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 64'd0;
    num_layers = 4'd0; start = 1'b0; layer_ready = 1'b0; exp_cfg = 64'd0; exp_pre = 4'd0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");
    tick();
    check("idle_engrst", eng_rst, 1);
    check("idle_busy", busy, 0);

    // Three-layer network: conv, pool, fc
    d_conv = mk_desc(4'd1, 8'd8, 8'd2, 8'd0, 2'd0, 8'd6, 8'd3, 1'b0, 4'd0, 2'd1);
    d_pool = mk_desc(4'd2, 8'd0, 8'd0, 8'd4, 2'd0, 8'd0, 8'd0, 1'b0, 4'd2, 2'd0);
    d_fc   = mk_desc(4'd3, 8'd0, 8'd0, 8'd0, 2'd0, 8'd12, 8'd32, 1'b0, 4'd0, 2'd0);
    write_desc(0, d_conv); write_desc(1, d_pool); write_desc(2, d_fc);
    for (int i = 3; i < 8; i++) write_desc(i, rand_desc(4'd1));
    do_run(3, 1'b0, 1'b0, 99, e, fn);
    check("t1_edges", e, 4);
    check("t1_final_num", fn, 3);
    check("t1_fc_ks", cfg_bus[45:38], 8'd32);
    check("t1_fc_kn", cfg_bus[37:30], 8'd12);

    // layer_ready high across start is not an edge
    do_run(3, 1'b1, 1'b0, 99, e, fn);
    check("t2_edges", e, 4);

    // Timeout with no ready edge
    start = 1'b1; num_layers = 4'd3; tick(); start = 1'b0;
    tick(); tick();
    repeat (15) tick();
    check("tmo_before_err", err, 0);
    check("tmo_before_busy", busy, 1);
    tick();
    check("tmo_err", err, 1);
    check("tmo_engrst", eng_rst, 1);
    check("tmo_busy", busy, 0);
    check("tmo_done", done, 0);
    check("tmo_cnt", cycle_cnt, 18);
    frz = cycle_cnt;
    repeat (3) tick();
    check("tmo_cnt_frozen", cycle_cnt, frz);
    check("tmo_err_sticky", err, 1);

    // Writes and start during run are ignored; rerun matches the model table
    do_run(3, 1'b0, 1'b1, 99, e, fn);
    check("t4_edges", e, 4);
    do_run(3, 1'b0, 1'b1, 99, e, fn);
    check("t4_rerun_num", fn, 3);

    // Reset in the middle of the fc layer
    do_run(3, 1'b0, 1'b0, 3, e, fn);
    check("t6_at_fc", layer_type, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cfg = 64'd0;
    check_reset_outputs("midrst");
    do_run(3, 1'b0, 1'b0, 99, e, fn);
    check("t6_rerun_edges", e, 4);

    // Table of run shapes
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) write_desc(i, rand_desc(4'(1 + $urandom_range(0, 2))));
      if (vecs[v].stop_idx < 8) write_desc(vecs[v].stop_idx, rand_desc(vecs[v].stop_type));
      do_run(vecs[v].nl, 1'b0, 1'($urandom), 99, e, fn);
      check("vec_edges", e, vecs[v].exp_edges);
      check("vec_final_num", fn, vecs[v].exp_num);
    end

    // Randomized runs against the model
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 8; i++) write_desc(i, rand_desc(rand_type()));
      nl = $urandom_range(0, 15);
      do_run(nl, 1'($urandom), 1'($urandom), 99, e, fn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
